alu_cmd_driver: RTL and testbench

- Initiator side of the simple ALU operand/start/result interface.
- Accepts one command at a time on a valid/ready request channel and drives the ALU's `start`, `a`, `b` and `mode_select` inputs.
- Waits the fixed ALU latency, captures the ALU result and returns it with its tag on a valid/ready response channel.
- Sits between the stimulus/sequencer layer and the ALU; catches divide-by-zero before issue.

---
 rtl/tb_pkg.sv | 36 +++
 rtl/alu_cmd_driver.sv | 143 ++++++++++++++
 tb/tb_alu_cmd_driver.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pkg
// Description : Shared ALU opcode encoding, data-path sizing and the command
//               driver state type.
// Revision    : 1.0 - initial release
// ============================================================================
package tb_pkg;

    localparam int DATA_W     = 32;
    localparam int RESULT_LAT = 2;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        MUL = 3'd2,
        DIV = 3'd3,
        MOD = 3'd4,
        ACC = 3'd5,
        MAC = 3'd6
    } opcode;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } drv_state_t;

    // Operations whose zero divisor must be trapped before reaching the ALU.
    function automatic logic is_div_mod(input opcode op);
        return (op == DIV) || (op == MOD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_cmd_driver.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_driver
// Description : Issues one command at a time to the ALU, waits its fixed
//               latency and returns the captured result with its tag.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_driver #(
    parameter int DATA_W     = tb_pkg::DATA_W,
    parameter int TAG_W      = 4,
    parameter int RESULT_LAT = tb_pkg::RESULT_LAT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  tb_pkg::opcode     cmd_op,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic              alu_start,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output tb_pkg::opcode     alu_mode,
    input  logic [DATA_W-1:0] alu_c,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_err,
    output logic              busy
);

    import tb_pkg::*;

    localparam int                c_cnt_w    = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(RESULT_LAT - 1);

    drv_state_t          r_state;
    drv_state_t          w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt;
    opcode               r_op;
    logic [TAG_W-1:0]    r_tag;
    logic [DATA_W-1:0]   r_alu_a;
    logic [DATA_W-1:0]   r_alu_b;
    opcode               r_alu_mode;
    logic [DATA_W-1:0]   r_rsp_data;
    logic [TAG_W-1:0]    r_rsp_tag;
    logic                r_rsp_err;
    logic                w_accept;
    logic                w_div_zero;
    logic                w_capture;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_div_zero  = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                w_div_zero = is_div_mod(cmd_op) && (cmd_b == '0);
                if (cmd_valid && !reset) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_div_zero ? RESP : ISSUE;
                end
            end
            ISSUE: w_state_nxt = WAIT;
            WAIT: begin
                if (r_cnt == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The ALU mode only follows the new op one cycle after the start strobe,
    // so an ACC/MAC sees the previous command's settled result as its base.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt      <= '0;
            r_op       <= ADD;
            r_tag      <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_mode <= ADD;
            r_rsp_data <= '0;
            r_rsp_tag  <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op  <= cmd_op;
                r_tag <= cmd_tag;
                if (w_div_zero) begin
                    r_rsp_data <= '0;
                    r_rsp_tag  <= cmd_tag;
                    r_rsp_err  <= 1'b1;
                end else begin
                    r_alu_a <= cmd_a;
                    r_alu_b <= cmd_b;
                end
            end
            if (r_state == ISSUE) begin
                r_alu_mode <= r_op;
                r_cnt      <= c_cnt_load;
            end else if ((r_state == WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_capture) begin
                r_rsp_data <= alu_c;
                r_rsp_tag  <= r_tag;
                r_rsp_err  <= 1'b0;
            end
        end
    end

    assign cmd_ready = (r_state == IDLE) && !reset;
    assign alu_start = (r_state == ISSUE);
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_mode  = r_alu_mode;
    assign rsp_valid = (r_state == RESP);
    assign rsp_data  = r_rsp_data;
    assign rsp_tag   = r_rsp_tag;
    assign rsp_err   = r_rsp_err;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_cmd_driver
// Description : Directed self-checking bench for alu_cmd_driver with a
//               behavioural two-stage accumulating ALU attached.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_driver;
    import tb_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    opcode       cmd_op;
    logic [3:0]  cmd_tag;
    logic        alu_start;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    opcode       alu_mode;
    logic [31:0] alu_c;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_tag;
    logic        rsp_err;
    logic        busy;

    int checks    = 0;
    int errors    = 0;
    int start_cnt = 0;

    alu_cmd_driver #(.DATA_W(32), .TAG_W(4), .RESULT_LAT(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_op    (cmd_op),
        .cmd_tag   (cmd_tag),
        .alu_start (alu_start),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_mode  (alu_mode),
        .alu_c     (alu_c),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_tag   (rsp_tag),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    // ALU model: operands load on start, result register recomputes every cycle.
    logic [31:0] m_ra = '0;
    logic [31:0] m_rb = '0;
    logic [31:0] m_c  = '0;
    always @(posedge clock) begin
        if (alu_start) begin
            m_ra <= alu_a;
            m_rb <= alu_b;
        end
        case (alu_mode)
            ADD:     m_c <= m_ra + m_rb;
            SUB:     m_c <= m_ra - m_rb;
            MUL:     m_c <= m_ra * m_rb;
            DIV:     m_c <= (m_rb == '0) ? '0 : m_ra / m_rb;
            MOD:     m_c <= (m_rb == '0) ? '0 : m_ra % m_rb;
            ACC:     m_c <= m_c + m_ra;
            MAC:     m_c <= m_c + m_ra * m_rb;
            default: m_c <= m_c;
        endcase
        if (alu_start) start_cnt <= start_cnt + 1;
    end
    assign alu_c = m_c;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one command, returns the response fields and the cycles from the
    // sample after the accept edge until rsp_valid was seen.
    task automatic run_cmd(input opcode op, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] tag, output logic [31:0] d,
                           output logic [3:0] t, output logic e, output int lat);
        int guard;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_tag   = tag;
        guard     = 0;
        while (!cmd_ready && guard < 20) begin
            tick();
            guard++;
        end
        chk("accept_timeout", 64'(guard < 20), 64'd1);
        tick();
        cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("rsp_timeout", 64'(rsp_valid), 64'd1);
        d = rsp_data;
        t = rsp_tag;
        e = rsp_err;
    endtask

    initial begin
        logic [31:0] d;
        logic [3:0]  t;
        logic        e;
        int          lat;
        int          s0;
        logic        seen;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_op    = ADD;
        cmd_tag   = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_alu_start", 64'(alu_start), 64'd0);
        chk("rst_alu_mode",  64'(alu_mode),  64'(ADD));
        chk("rst_alu_a",     64'(alu_a),     64'd0);
        chk("rst_rsp_data",  64'(rsp_data),  64'd0);
        chk("rst_rsp_err",   64'(rsp_err),   64'd0);
        reset = 1'b0;
        #1;
        chk("cmd_ready_post_rst", 64'(cmd_ready), 64'd1);

        // ADD 7+5 cycle by cycle
        s0        = start_cnt;
        cmd_valid = 1'b1;
        cmd_op    = ADD;
        cmd_a     = 32'd7;
        cmd_b     = 32'd5;
        cmd_tag   = 4'd3;
        tick();
        cmd_valid = 1'b0;
        chk("add_issue_start", 64'(alu_start), 64'd1);
        chk("add_issue_a",     64'(alu_a),     64'd7);
        chk("add_issue_b",     64'(alu_b),     64'd5);
        chk("add_issue_ready", 64'(cmd_ready), 64'd0);
        chk("add_issue_busy",  64'(busy),      64'd1);
        tick();
        chk("add_wait1_start", 64'(alu_start), 64'd0);
        chk("add_wait1_valid", 64'(rsp_valid), 64'd0);
        tick();
        chk("add_wait2_valid", 64'(rsp_valid), 64'd0);
        tick();
        chk("add_resp_valid",  64'(rsp_valid), 64'd1);
        chk("add_resp_data",   64'(rsp_data),  64'd12);
        chk("add_resp_tag",    64'(rsp_tag),   64'd3);
        chk("add_resp_err",    64'(rsp_err),   64'd0);
        chk("add_start_pulses", 64'(start_cnt - s0), 64'd1);
        tick();
        chk("add_done_valid",  64'(rsp_valid), 64'd0);
        chk("add_done_ready",  64'(cmd_ready), 64'd1);

        run_cmd(SUB, 32'd3, 32'd5, 4'd1, d, t, e, lat);
        chk("sub_data", 64'(d), 64'hFFFF_FFFE);
        chk("sub_lat",  64'(lat), 64'd3);
        tick();
        run_cmd(MUL, 32'h0001_0000, 32'h0001_0000, 4'd2, d, t, e, lat);
        chk("mul_wrap_data", 64'(d), 64'd0);
        chk("mul_tag",       64'(t), 64'd2);
        tick();

        // Divide and modulo by zero are trapped without touching the ALU
        s0 = start_cnt;
        run_cmd(DIV, 32'd9, 32'd0, 4'd5, d, t, e, lat);
        chk("div0_err",  64'(e),   64'd1);
        chk("div0_data", 64'(d),   64'd0);
        chk("div0_tag",  64'(t),   64'd5);
        chk("div0_lat",  64'(lat), 64'd0);
        tick();
        run_cmd(MOD, 32'd9, 32'd0, 4'd6, d, t, e, lat);
        chk("mod0_err",  64'(e),   64'd1);
        chk("mod0_data", 64'(d),   64'd0);
        chk("mod0_lat",  64'(lat), 64'd0);
        chk("div_mod_no_start", 64'(start_cnt - s0), 64'd0);
        tick();

        run_cmd(ADD, 32'd5, 32'd0, 4'd7, d, t, e, lat);
        chk("acc_base", 64'(d), 64'd5);
        tick();
        run_cmd(ACC, 32'd3, 32'd0, 4'd8, d, t, e, lat);
        chk("acc_data", 64'(d), 64'd8);
        tick();
        run_cmd(ADD, 32'd2, 32'd0, 4'd9, d, t, e, lat);
        tick();
        run_cmd(MAC, 32'd3, 32'd4, 4'd10, d, t, e, lat);
        chk("mac_data", 64'(d), 64'd14);
        chk("mac_err",  64'(e), 64'd0);
        tick();

        // Backpressure with a second command waiting
        rsp_ready = 1'b0;
        s0        = start_cnt;
        run_cmd(ADD, 32'd1, 32'd1, 4'd9, d, t, e, lat);
        chk("bp_data", 64'(d), 64'd2);
        cmd_valid = 1'b1;
        cmd_op    = ADD;
        cmd_a     = 32'd4;
        cmd_b     = 32'd4;
        cmd_tag   = 4'd10;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold_valid", 64'(rsp_valid), 64'd1);
            chk("bp_hold_data",  64'(rsp_data),  64'd2);
            chk("bp_hold_tag",   64'(rsp_tag),   64'd9);
            chk("bp_hold_ready", 64'(cmd_ready), 64'd0);
        end
        chk("bp_single_start", 64'(start_cnt - s0), 64'd1);
        rsp_ready = 1'b1;
        tick();
        chk("bp_release_valid", 64'(rsp_valid), 64'd0);
        chk("bp_release_ready", 64'(cmd_ready), 64'd1);
        tick();
        cmd_valid = 1'b0;
        chk("bp_second_start", 64'(alu_start), 64'd1);
        chk("bp_second_a",     64'(alu_a),     64'd4);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("bp_second_lat",  64'(lat),      64'd3);
        chk("bp_second_data", 64'(rsp_data), 64'd8);
        chk("bp_second_tag",  64'(rsp_tag),  64'd10);
        tick();

        // Reset while waiting on the ALU
        cmd_valid = 1'b1;
        cmd_op    = MUL;
        cmd_a     = 32'd6;
        cmd_b     = 32'd7;
        cmd_tag   = 4'd11;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("mul_wait_mode", 64'(alu_mode), 64'(MUL));
        chk("mul_wait_busy", 64'(busy),     64'd1);
        reset = 1'b1;
        tick();
        chk("midrst_busy",  64'(busy),      64'd0);
        chk("midrst_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_mode",  64'(alu_mode),  64'(ADD));
        reset = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen = seen | rsp_valid;
        end
        chk("midrst_no_rsp", 64'(seen), 64'd0);
        run_cmd(ADD, 32'd1, 32'd1, 4'd12, d, t, e, lat);
        chk("post_rst_data", 64'(d), 64'd2);
        chk("post_rst_tag",  64'(t), 64'd12);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
